// File: rtl/alu_share_ctrl.sv
// ============================================================================
// Module      : alu_share_ctrl
// Description : Round-robin sharing of one WIDTH-bit add/AND ALU between two
//               valid/ready requesters, with a registered valid/ready response.
//               Optional macro ALU_GRANT_CNT_EN enables per-requester grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  input  logic             rsp_ready,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_prio;
  logic             w_grant0;
  logic             w_grant1;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;
  logic             r_id;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_carry;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic             r_rsp_id;

  // Arbitration: a lone valid wins outright; on contention the pointer decides.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == c_IDLE) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = ~r_prio;
        w_grant1 = r_prio;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_grant0 || w_grant1) w_next_state = c_EXEC;
      c_EXEC:  w_next_state = c_RESP;
      c_RESP:  if (rsp_ready) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Readies are masked while reset is held so they read 0 during reset.
  always_comb begin
    req0_ready = w_grant0 & ~rst;
    req1_ready = w_grant1 & ~rst;
    rsp_valid  = (r_state == c_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_sel  <= 1'b0;
      r_id   <= 1'b0;
    end else if (w_grant0) begin
      r_prio <= 1'b1;
      r_a    <= req0_a;
      r_b    <= req0_b;
      r_sel  <= req0_sel;
      r_id   <= 1'b0;
    end else if (w_grant1) begin
      r_prio <= 1'b0;
      r_a    <= req1_a;
      r_b    <= req1_b;
      r_sel  <= req1_sel;
      r_id   <= 1'b1;
    end
  end

  always_comb begin
    w_sum        = {1'b0, r_a} + {1'b0, r_b};
    w_alu_result = r_sel ? (r_a & r_b) : w_sum[WIDTH-1:0];
    w_alu_carry  = r_sel ? 1'b0 : w_sum[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_id     <= 1'b0;
    end else if (r_state == c_EXEC) begin
      r_rsp_result <= w_alu_result;
      r_rsp_carry  <= w_alu_carry;
      r_rsp_id     <= r_id;
    end
  end

  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_id     = r_rsp_id;

`ifdef ALU_GRANT_CNT_EN
  logic [7:0] r_grant_cnt0;
  logic [7:0] r_grant_cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt0 <= 8'd0;
      r_grant_cnt1 <= 8'd0;
    end else begin
      if (w_grant0) r_grant_cnt0 <= r_grant_cnt0 + 8'd1;
      if (w_grant1) r_grant_cnt1 <= r_grant_cnt1 + 8'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`else
  assign grant_cnt0 = 8'd0;
  assign grant_cnt1 = 8'd0;
`endif

endmodule

`default_nettype wire
